// File: rtl/rxecrcstrip_pkg.sv
// Shared constants and state encoding for the receive-side CRC-32 check/strip block.
package rxecrcstrip_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   // Only bit 0 and the ">= 8" test of the nibble count are consumed downstream.
   localparam int CNT_W = 12;
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(8);
   localparam logic [CNT_W-1:0] CNT_LAST_FILL = CNT_W'(7);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

endpackage

// File: rtl/rxecrcstrip_if.sv
// Nibble-stream bus between the MAC receive path and the CRC strip block.
interface rxecrcstrip_if;
   logic       i_ce;
   logic       i_en;
   logic       i_cancel;
   logic       i_v;
   logic [3:0] i_d;
   logic       o_v;
   logic [3:0] o_d;
   logic       o_err;

   modport master (
      output i_ce, i_en, i_cancel, i_v, i_d,
      input  o_v, o_d, o_err
   );

   modport slave (
      input  i_ce, i_en, i_cancel, i_v, i_d,
      output o_v, o_d, o_err
   );
endinterface

// File: rtl/rxecrcstrip_crc32_nibble.sv
// Combinational reflected CRC-32 update for one nibble, bit 0 consumed first.
module crc32_nibble
   import rxecrcstrip_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [3:0]  data,
   output logic [31:0] crc_out
);

   logic [31:0] stage [0:4];

   assign stage[0] = crc_in ^ {28'd0, data};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bit
         assign stage[gi+1] = stage[gi][0] ? ({1'b0, stage[gi][31:1]} ^ CRC32_POLY)
                                           : {1'b0, stage[gi][31:1]};
      end
   endgenerate

   assign crc_out = stage[4];

endmodule

// File: rtl/rxecrcstrip.sv
// Strips and checks the trailing 32-bit FCS of a nibble-wide receive stream,
// delaying data by eight nibbles so the FCS never reaches the output.
module rxecrcstrip
   import rxecrcstrip_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_reset,
   rxecrcstrip_if.slave  bus
);

   state_t           state_reg;
   logic             en_reg;
   logic [CNT_W-1:0] count_reg;
   logic [31:0]      crc_reg;
   logic [31:0]      dline_reg;
   logic             v_reg;
   logic [3:0]       d_reg;
   logic             err_reg;

   logic [31:0]      crc_seed;
   logic [31:0]      crc_next;
   logic [CNT_W-1:0] count_next;
   logic [31:0]      dline_next;
   logic             frame_bad;

   // A frame always starts from the init value, so IDLE seeds the update directly.
   assign crc_seed   = (state_reg == ST_IDLE) ? CRC32_INIT : crc_reg;
   assign count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + CNT_W'(1);
   assign dline_next = {dline_reg[27:0], bus.i_d};
   assign frame_bad  = (crc_reg != CRC32_RESIDUE) || (count_reg < CNT_FULL) || count_reg[0];

   crc32_nibble u_crc (
      .crc_in  (crc_seed),
      .data    (bus.i_d),
      .crc_out (crc_next)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= ST_IDLE;
         en_reg    <= 1'b0;
         count_reg <= '0;
         crc_reg   <= CRC32_INIT;
         dline_reg <= '0;
         v_reg     <= 1'b0;
         d_reg     <= 4'd0;
         err_reg   <= 1'b0;
      end else if (bus.i_ce) begin
         err_reg <= 1'b0;
         if (bus.i_cancel) begin
            v_reg     <= 1'b0;
            dline_reg <= '0;
            count_reg <= '0;
            crc_reg   <= CRC32_INIT;
            state_reg <= bus.i_v ? ST_FLUSH : ST_IDLE;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (bus.i_v) begin
                     en_reg <= bus.i_en;
                     if (bus.i_en) begin
                        state_reg <= ST_FILL;
                        count_reg <= CNT_W'(1);
                        crc_reg   <= crc_next;
                        dline_reg <= {28'd0, bus.i_d};
                        v_reg     <= 1'b0;
                     end else begin
                        // Pass-through frames reuse STREAM with the latched enable low.
                        state_reg <= ST_STREAM;
                        v_reg     <= 1'b1;
                        d_reg     <= bus.i_d;
                     end
                  end else begin
                     v_reg <= 1'b0;
                  end
               end

               ST_FILL: begin
                  v_reg <= 1'b0;
                  if (bus.i_v) begin
                     crc_reg   <= crc_next;
                     count_reg <= count_next;
                     dline_reg <= dline_next;
                     if (count_reg == CNT_LAST_FILL) begin
                        state_reg <= ST_STREAM;
                     end
                  end else begin
                     err_reg   <= frame_bad;
                     state_reg <= ST_IDLE;
                  end
               end

               ST_STREAM: begin
                  if (!en_reg) begin
                     v_reg <= bus.i_v;
                     d_reg <= bus.i_d;
                     if (!bus.i_v) begin
                        state_reg <= ST_IDLE;
                     end
                  end else if (bus.i_v) begin
                     v_reg     <= 1'b1;
                     d_reg     <= dline_reg[31:28];
                     crc_reg   <= crc_next;
                     count_reg <= count_next;
                     dline_reg <= dline_next;
                  end else begin
                     v_reg     <= 1'b0;
                     err_reg   <= frame_bad;
                     state_reg <= ST_IDLE;
                  end
               end

               ST_FLUSH: begin
                  v_reg <= 1'b0;
                  if (!bus.i_v) begin
                     state_reg <= ST_IDLE;
                  end
               end

               default: begin
                  v_reg     <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.o_v   = v_reg;
   assign bus.o_d   = d_reg;
   assign bus.o_err = err_reg;

endmodule

// File: tb/tb_rxecrcstrip.sv
// Directed bench for rxecrcstrip: good/corrupt/runt/cancel frames, pass-through, async reset.
module tb_rxecrcstrip;

   logic i_clk   = 1'b0;
   logic i_reset = 1'b0;

   always #5 i_clk = ~i_clk;

   rxecrcstrip_if bus ();

   rxecrcstrip dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [3:0] frame [0:63];
   logic [3:0] got [$];
   int err_cnt;
   int err_cyc;
   int end_cyc;
   int cyc = 0;

   task automatic tick();
      @(posedge i_clk);
      #1;
      cyc++;
      if (bus.o_v === 1'b1) got.push_back(bus.o_d);
      if (bus.o_err === 1'b1) begin
         err_cnt++;
         if (err_cyc < 0) err_cyc = cyc;
      end
   endtask

   task automatic clear_obs();
      got.delete();
      err_cnt = 0;
      err_cyc = -1;
   endtask

   task automatic drive_frame(input int n, input int cancel_at, input int idle_after);
      for (int i = 0; i < n; i++) begin
         bus.i_v      = 1'b1;
         bus.i_d      = frame[i];
         bus.i_cancel = (i == cancel_at);
         tick();
      end
      bus.i_v      = 1'b0;
      bus.i_d      = 4'd0;
      bus.i_cancel = 1'b0;
      end_cyc      = cyc + 1;
      for (int j = 0; j < idle_after; j++) tick();
   endtask

   // "123456789" followed by its FCS bytes 26 39 F4 CB, low nibble first.
   task automatic load_good();
      logic [7:0] b;
      logic [7:0] fcs [0:3];
      fcs[0] = 8'h26; fcs[1] = 8'h39; fcs[2] = 8'hF4; fcs[3] = 8'hCB;
      for (int i = 0; i < 9; i++) begin
         b = 8'h31 + i[7:0];
         frame[2*i]   = b[3:0];
         frame[2*i+1] = b[7:4];
      end
      for (int i = 0; i < 4; i++) begin
         b = fcs[i];
         frame[18+2*i] = b[3:0];
         frame[19+2*i] = b[7:4];
      end
   endtask

   task automatic test_reset();
      #1 i_reset = 1'b1;
      #1;
      total++; if (bus.o_v !== 1'b0)   begin bad++; $display("FAIL reset_o_v: got %b want 0", bus.o_v); end
      total++; if (bus.o_d !== 4'h0)   begin bad++; $display("FAIL reset_o_d: got %h want 0", bus.o_d); end
      total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL reset_o_err: got %b want 0", bus.o_err); end
      tick(); tick();
      i_reset = 1'b0;
      clear_obs();
      for (int i = 0; i < 3; i++) tick();
      total++; if (got.size() != 0 || err_cnt != 0) begin
         bad++; $display("FAIL idle_quiet: got v=%0d err=%0d want 0 0", got.size(), err_cnt);
      end
      $display("test_reset done");
   endtask

   task automatic test_good_frame();
      logic [3:0] exp;
      logic [3:0] obs;
      load_good();
      clear_obs();
      drive_frame(26, -1, 3);
      total++; if (got.size() != 18) begin bad++; $display("FAIL good_count: got %0d want 18", got.size()); end
      for (int i = 0; i < 18; i++) begin
         exp = (i % 2 == 1) ? 4'h3 : 4'(i / 2 + 1);
         obs = (i < got.size()) ? got[i] : 4'hx;
         total++; if (obs !== exp) begin bad++; $display("FAIL good_nib%0d: got %h want %h", i, obs, exp); end
      end
      total++; if (err_cnt != 0) begin bad++; $display("FAIL good_err: got %0d want 0", err_cnt); end
      $display("test_good_frame: %0d nibbles, err=%0d", got.size(), err_cnt);
   endtask

   task automatic test_corrupt_frame();
      load_good();
      frame[0] = 4'h0;
      clear_obs();
      drive_frame(26, -1, 3);
      total++; if (got.size() != 18) begin bad++; $display("FAIL corrupt_count: got %0d want 18", got.size()); end
      total++; if (got.size() < 2 || got[0] !== 4'h0 || got[1] !== 4'h3) begin
         bad++; $display("FAIL corrupt_first: got size %0d want first nibbles 0,3", got.size());
      end
      total++; if (err_cnt != 1) begin bad++; $display("FAIL corrupt_err_width: got %0d want 1", err_cnt); end
      total++; if (err_cyc != end_cyc) begin bad++; $display("FAIL corrupt_err_time: got %0d want %0d", err_cyc, end_cyc); end
      $display("test_corrupt_frame: %0d nibbles, err=%0d", got.size(), err_cnt);
   endtask

   task automatic test_runt();
      load_good();
      clear_obs();
      drive_frame(6, -1, 3);
      total++; if (got.size() != 0) begin bad++; $display("FAIL runt_ov: got %0d nibbles want 0", got.size()); end
      total++; if (err_cnt != 1) begin bad++; $display("FAIL runt_err: got %0d want 1", err_cnt); end
      total++; if (err_cyc != end_cyc) begin bad++; $display("FAIL runt_err_time: got %0d want %0d", err_cyc, end_cyc); end
      $display("test_runt: %0d nibbles, err=%0d", got.size(), err_cnt);
   endtask

   task automatic test_cancel();
      load_good();
      clear_obs();
      drive_frame(26, 11, 3);
      total++; if (got.size() != 3) begin bad++; $display("FAIL cancel_count: got %0d want 3", got.size()); end
      total++; if (got.size() < 3 || got[0] !== 4'h1 || got[1] !== 4'h3 || got[2] !== 4'h2) begin
         bad++; $display("FAIL cancel_data: got size %0d want nibbles 1,3,2", got.size());
      end
      total++; if (err_cnt != 0) begin bad++; $display("FAIL cancel_err: got %0d want 0", err_cnt); end
      load_good();
      clear_obs();
      drive_frame(26, -1, 3);
      total++; if (got.size() != 18) begin bad++; $display("FAIL cancel_next_count: got %0d want 18", got.size()); end
      total++; if (got.size() < 18 || got[16] !== 4'h9 || got[17] !== 4'h3) begin
         bad++; $display("FAIL cancel_next_tail: got size %0d want last nibbles 9,3", got.size());
      end
      total++; if (err_cnt != 0) begin bad++; $display("FAIL cancel_next_err: got %0d want 0", err_cnt); end
      $display("test_cancel: next frame %0d nibbles, err=%0d", got.size(), err_cnt);
   endtask

   task automatic test_back_to_back();
      load_good();
      frame[0] = 4'h0;
      clear_obs();
      drive_frame(26, -1, 1);
      total++; if (err_cnt != 1 || err_cyc != end_cyc) begin
         bad++; $display("FAIL b2b_prev_err: got cnt %0d at %0d want 1 at %0d", err_cnt, err_cyc, end_cyc);
      end
      load_good();
      clear_obs();
      drive_frame(26, -1, 3);
      total++; if (got.size() != 18) begin bad++; $display("FAIL b2b_count: got %0d want 18", got.size()); end
      total++; if (got.size() < 1 || got[0] !== 4'h1) begin bad++; $display("FAIL b2b_first: got size %0d want first nibble 1", got.size()); end
      total++; if (err_cnt != 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", err_cnt); end
      $display("test_back_to_back: %0d nibbles, err=%0d", got.size(), err_cnt);
   endtask

   task automatic test_passthrough_throttle();
      logic [3:0] pt [0:3];
      pt[0] = 4'hA; pt[1] = 4'h5; pt[2] = 4'hC; pt[3] = 4'h3;
      bus.i_en = 1'b0;
      clear_obs();
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 4; c++) begin
            bus.i_ce = (c == 0);
            bus.i_v  = 1'b1;
            bus.i_d  = pt[i];
            bus.i_en = (i >= 2);
            tick();
            total++; if (bus.o_v !== 1'b1 || bus.o_d !== pt[i]) begin
               bad++; $display("FAIL pt_nib%0d_clk%0d: got v=%b d=%h want v=1 d=%h", i, c, bus.o_v, bus.o_d, pt[i]);
            end
            bus.i_d = ~pt[i];
         end
      end
      for (int c = 0; c < 4; c++) begin
         bus.i_ce = (c == 0);
         bus.i_v  = 1'b0;
         tick();
         total++; if (bus.o_v !== 1'b0) begin bad++; $display("FAIL pt_end_clk%0d: got v=%b want 0", c, bus.o_v); end
      end
      total++; if (err_cnt != 0) begin bad++; $display("FAIL pt_err: got %0d want 0", err_cnt); end
      bus.i_ce = 1'b1;
      bus.i_en = 1'b1;
      $display("test_passthrough_throttle: err=%0d", err_cnt);
   endtask

   task automatic test_async_reset();
      load_good();
      clear_obs();
      for (int i = 0; i < 12; i++) begin
         bus.i_v = 1'b1;
         bus.i_d = frame[i];
         tick();
      end
      total++; if (bus.o_v !== 1'b1 || bus.o_d !== 4'h3) begin
         bad++; $display("FAIL ar_pre: got v=%b d=%h want v=1 d=3", bus.o_v, bus.o_d);
      end
      #3 i_reset = 1'b1;
      #1;
      total++; if (bus.o_v !== 1'b0 || bus.o_d !== 4'h0 || bus.o_err !== 1'b0) begin
         bad++; $display("FAIL ar_immediate: got v=%b d=%h err=%b want 0 0 0", bus.o_v, bus.o_d, bus.o_err);
      end
      @(posedge i_clk);
      #1 i_reset = 1'b0;
      clear_obs();
      for (int i = 12; i < 26; i++) begin
         bus.i_v = 1'b1;
         bus.i_d = frame[i];
         tick();
      end
      bus.i_v = 1'b0;
      end_cyc = cyc + 1;
      for (int j = 0; j < 3; j++) tick();
      total++; if (got.size() != 6 || got[0] !== 4'h7) begin
         bad++; $display("FAIL ar_tail_data: got %0d nibbles want 6 starting with 7", got.size());
      end
      total++; if (err_cnt != 1 || err_cyc != end_cyc) begin
         bad++; $display("FAIL ar_tail_err: got cnt %0d at %0d want 1 at %0d", err_cnt, err_cyc, end_cyc);
      end
      $display("test_async_reset: tail %0d nibbles, err=%0d", got.size(), err_cnt);
   endtask

   initial begin
      bus.i_ce     = 1'b1;
      bus.i_en     = 1'b1;
      bus.i_cancel = 1'b0;
      bus.i_v      = 1'b0;
      bus.i_d      = 4'h0;
      test_reset();
      test_good_frame();
      test_corrupt_frame();
      test_runt();
      test_cancel();
      test_back_to_back();
      test_passthrough_throttle();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rxecrcstrip.md
RXECRCSTRIP -- requirements
Module: rxecrcstrip

Interface
REQ-001 SHALL have ports: i_clk, input, 1, system clock; sole clock domain.
REQ-002 SHALL have i_reset, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have i_ce, input, 1, nibble-rate clock enable; all state advances only when i_ce=1.
REQ-004 SHALL have i_en, input, 1, enables CRC check/strip; 0 means pass-through.
REQ-005 SHALL have i_cancel, input, 1, abort current frame.
REQ-006 SHALL have i_v, input, 1, nibble valid; i_d, input, 4, nibble data, low nibble of each byte first, preamble/SFD already removed.
REQ-007 SHALL have o_v, output, 1, output nibble valid; o_d, output, 4, output nibble.
REQ-008 SHALL have o_err, output, 1, one-i_ce-cycle pulse flagging a bad frame.

Function
REQ-009 SHALL hold all outputs and state unchanged on clocks where i_ce=0.
REQ-010 SHALL latch i_en at frame start (first i_v=1 in IDLE); mid-frame i_en changes SHALL have no effect until the next frame.
REQ-011 Pass-through (latched i_en=0): o_v<=i_v and o_d<=i_d on each i_ce; o_err stays 0.
REQ-012 States: IDLE, FILL, STREAM, FLUSH (wait for i_v low).
REQ-013 IDLE -> FILL on i_v=1 with latched i_en=1; nibble count = 1; CRC register initialised to 32'hFFFFFFFF, then updated with the first nibble.
REQ-014 FILL: shift each valid nibble into an 8-nibble (32-bit) delay line; o_v=0; FILL -> STREAM when the 8th nibble is accepted.
REQ-015 STREAM: each accepted nibble k+8 SHALL cause o_v=1, o_d=nibble k on the next clock, so that the final 8 nibbles (FCS) are never emitted.
REQ-016 CRC SHALL be CRC-32, reflected polynomial 32'hEDB88320, updated per nibble bit0 first, over all nibbles including the FCS, with no final inversion.
REQ-017 End of frame (i_v=0 in FILL or STREAM): o_v=0; o_err=1 for one i_ce cycle if CRC register != 32'hDEBB20E3, or nibble count <8, or nibble count odd; otherwise o_err=0; next state IDLE.
REQ-018 Nibble counter SHALL saturate at its maximum (12 bits minimum), never wrap; only bit 0 and the >=8 test are consumed.
REQ-019 i_cancel=1 in any state: o_v=0 next clock, o_err=0, discard delay line; go to FLUSH if i_v=1, else IDLE.
REQ-020 FLUSH: ignore input, o_v=0; -> IDLE when i_v=0.
REQ-021 i_v=0 in IDLE with no frame pending SHALL produce o_v=0, o_err=0.
REQ-022 A new frame starting on the i_ce cycle immediately after end-of-frame SHALL be accepted normally, with the o_err pulse for the previous frame still issued.

Reset
REQ-023 On i_reset=1, immediately: o_v=0, o_d=0, o_err=0, state IDLE, count 0, CRC=32'hFFFFFFFF, delay line 0, latched enable 0.
REQ-024 Reset mid-frame SHALL drop the frame; the remainder of the frame after release SHALL be treated as a new frame.

Structure
REQ-025 Shared package SHALL hold CRC32_POLY (32'hEDB88320), CRC32_INIT (32'hFFFFFFFF), CRC32_RESIDUE (32'hDEBB20E3), and the state encoding.
REQ-026 One combinational sub-module crc32_nibble (32-bit CRC in, 4-bit data in, 32-bit CRC out) SHALL implement the per-nibble update.

Verification
REQ-027 Good frame: bytes 31..39 ("123456789") then FCS 26 39 F4 CB, low nibble first, i_ce=1 -> 18 o_v nibbles 1,3,2,3,...,9,3 in order; o_err=0.
REQ-028 Corrupt frame: same frame with the first nibble = 0 -> same nibble count emitted (first o_d=0), o_err=1 for one cycle after i_v falls.
REQ-029 Runt: 6 valid nibbles -> o_v never asserted, o_err=1.
REQ-030 Cancel: i_cancel pulse at nibble 12 of the good frame with i_v still high -> o_v=0 from next clock to frame end, o_err=0, next good frame passes cleanly.
REQ-031 i_ce throttled 1-in-4 plus i_en=0 frame -> pass-through with outputs held between enables, 1-clock latency, o_err=0; i_en toggled mid-frame has no effect.
REQ-032 Asynchronous i_reset asserted mid-STREAM -> outputs 0 without waiting for a clock edge; after release, the tail of that frame yields o_err=1.
